// File: rtl/cam_fifo_sdram_writer.sv
// cam_fifo_sdram_writer
// Drains RGB565 pixels from the capture FIFO in fixed-length bursts into one of
// two SDRAM frame buffers. Buffers swap at a frame boundary only when the frame
// that just finished was written completely, so the display side never reads a
// torn frame.
module cam_fifo_sdram_writer #(
   parameter int unsigned       BURST_LEN   = 256,
   parameter int unsigned       FRAME_WORDS = 307200,
   parameter int unsigned       ADDR_W      = 24,
   parameter logic [ADDR_W-1:0] BANK1_BASE  = 24'h080000
) (
   input  logic              clk_100,
   input  logic              rst_n,
   input  logic [9:0]        fifo_count,
   input  logic [15:0]       fifo_dout,
   output logic              fifo_rd_en,
   input  logic              frame_start,
   output logic              wr_req,
   input  logic              wr_gnt,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [15:0]       wr_data,
   output logic              wr_valid,
   output logic              disp_bank,
   output logic              frame_done,
   output logic              frame_err,
   output logic              busy
);

   // One extra bit so the beat counter can hold BURST_LEN itself, which marks
   // the trailing cycle where the last word is presented on wr_data.
   localparam int unsigned      CNT_W       = $clog2(BURST_LEN) + 1;
   localparam logic [CNT_W-1:0] BURST_BEATS = CNT_W'(BURST_LEN);
   localparam logic [9:0]       BURST_FIFO  = 10'(BURST_LEN);
   localparam logic [18:0]      BURST_WORDS = 19'(BURST_LEN);
   localparam logic [18:0]      FRAME_CNT   = 19'(FRAME_WORDS);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] REQ     = 3'd1;
   localparam logic [2:0] STREAM  = 3'd2;
   localparam logic [2:0] DISCARD = 3'd3;
   localparam logic [2:0] SWAP    = 3'd4;

   logic [2:0]        state;
   logic [2:0]        state_nxt;
   logic [18:0]       word_cnt;
   logic [CNT_W-1:0]  beat_cnt;
   logic              wr_bank;
   logic              start_pend;
   logic              frame_full;
   logic              stream_rd;
   logic              stream_last;
   logic              discard_rd;
   logic              rd_vld_p1;
   logic [ADDR_W-1:0] burst_addr;

   assign frame_full  = (word_cnt == FRAME_CNT);
   assign stream_rd   = (state == STREAM) && (beat_cnt < BURST_BEATS);
   assign stream_last = (state == STREAM) && (beat_cnt == BURST_BEATS);
   assign discard_rd  = (state == DISCARD) && (fifo_count != 10'd0) && !start_pend;
   assign burst_addr  = (wr_bank ? BANK1_BASE : '0) + ADDR_W'(word_cnt);

   // FIFO data feeds the controller directly; its valid is the read strobe delayed
   assign fifo_rd_en = stream_rd | discard_rd;
   assign wr_data    = fifo_dout;
   assign wr_valid   = rd_vld_p1;
   assign wr_req     = (state == REQ);
   assign busy       = (state != IDLE);
   assign frame_done = (state == SWAP) && frame_full;
   assign frame_err  = (state == SWAP) && !frame_full;

   // Next-state decode; a pending frame boundary outranks any new burst
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start_pend)
               state_nxt = SWAP;
            else if (frame_full && (fifo_count != 10'd0))
               state_nxt = DISCARD;
            else if ((fifo_count >= BURST_FIFO) && (word_cnt < FRAME_CNT))
               state_nxt = REQ;
         end
         REQ:     if (wr_gnt) state_nxt = STREAM;
         STREAM:  if (stream_last) state_nxt = IDLE;
         DISCARD: if ((fifo_count == 10'd0) || start_pend) state_nxt = IDLE;
         SWAP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register, burst beat counter and the read-to-valid delay stage
   always_ff @(posedge clk_100 or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         beat_cnt  <= '0;
         rd_vld_p1 <= 1'b0;
      end else begin
         state     <= state_nxt;
         rd_vld_p1 <= stream_rd;
         if (state != STREAM)
            beat_cnt <= '0;
         else if (stream_rd)
            beat_cnt <= beat_cnt + CNT_W'(1);
      end
   end

   // Burst address is captured on the way into REQ and held until the burst ends
   always_ff @(posedge clk_100 or negedge rst_n) begin
      if (!rst_n)
         wr_addr <= '0;
      else if ((state == IDLE) && (state_nxt == REQ))
         wr_addr <= burst_addr;
   end

   // Frame word count and ping-pong bank bookkeeping
   always_ff @(posedge clk_100 or negedge rst_n) begin
      if (!rst_n) begin
         word_cnt  <= '0;
         wr_bank   <= 1'b0;
         disp_bank <= 1'b1;
      end else begin
         if (stream_last)
            word_cnt <= word_cnt + BURST_WORDS;
         else if (state == SWAP)
            word_cnt <= '0;
         if ((state == SWAP) && frame_full) begin
            disp_bank <= wr_bank;
            wr_bank   <= ~wr_bank;
         end
      end
   end

   // Frame boundary latch; a new pulse wins over the clear issued by SWAP
   always_ff @(posedge clk_100 or negedge rst_n) begin
      if (!rst_n)
         start_pend <= 1'b0;
      else if (frame_start)
         start_pend <= 1'b1;
      else if (state == SWAP)
         start_pend <= 1'b0;
   end

endmodule

// File: tb/tb_cam_fifo_sdram_writer.sv
// Testbench for cam_fifo_sdram_writer: FIFO and SDRAM controller models driven
// cycle by cycle, with expectations from a frame/burst-level reference model.
module tb_cam_fifo_sdram_writer;

   localparam int              BL    = 16;
   localparam int              FW    = 64;
   localparam int              AW    = 24;
   localparam logic [AW-1:0]   BASE1 = 24'h080000;

   logic          clk_100 = 1'b0;
   logic          rst_n;
   logic [9:0]    fifo_count;
   logic [15:0]   fifo_dout;
   logic          fifo_rd_en;
   logic          frame_start;
   logic          wr_req;
   logic          wr_gnt;
   logic [AW-1:0] wr_addr;
   logic [15:0]   wr_data;
   logic          wr_valid;
   logic          disp_bank;
   logic          frame_done;
   logic          frame_err;
   logic          busy;

   cam_fifo_sdram_writer #(
      .BURST_LEN(BL), .FRAME_WORDS(FW), .ADDR_W(AW), .BANK1_BASE(BASE1)
   ) dut (
      .clk_100(clk_100), .rst_n(rst_n), .fifo_count(fifo_count), .fifo_dout(fifo_dout),
      .fifo_rd_en(fifo_rd_en), .frame_start(frame_start), .wr_req(wr_req), .wr_gnt(wr_gnt),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_valid(wr_valid), .disp_bank(disp_bank),
      .frame_done(frame_done), .frame_err(frame_err), .busy(busy)
   );

   always #5 clk_100 = ~clk_100;

   // scoreboard counters
   int n_cmp = 0;
   int n_bad = 0;

   // environment state
   logic [15:0]   fifo_q[$];
   logic [15:0]   exp_q[$];
   logic [15:0]   cap_q[$];
   logic [AW-1:0] addr_q[$];
   int cyc = 0;
   int gnt_delay = 0, gnt_wait = 0, gnt_max = 4;
   int n_rd, n_vld, n_req, n_done, n_err, addr_moved;
   int rd_first, vld_first, vld_last, gnt_cyc, gnt_first, err_cyc;

   // reference model: frame-level view of the writer
   int   m_cnt  = 0;
   logic m_bank = 1'b0;
   logic m_disp = 1'b1;

   function automatic logic [AW-1:0] m_addr(input int off);
      return (m_bank ? BASE1 : '0) + AW'(m_cnt + off);
   endfunction

   task automatic model_frame_boundary(output bit expect_done);
      expect_done = (m_cnt == FW);
      if (expect_done) begin
         m_disp = m_bank;
         m_bank = ~m_bank;
      end
      m_cnt = 0;
   endtask

   task automatic clear_stats();
      n_rd = 0; n_vld = 0; n_req = 0; n_done = 0; n_err = 0; addr_moved = 0;
      rd_first = -1; vld_first = -1; vld_last = -1; gnt_cyc = -1; gnt_first = -1; err_cyc = -1;
      cap_q.delete();
      addr_q.delete();
   endtask

   task automatic push_pixels(input int n);
      for (int i = 0; i < n; i++) begin
         logic [15:0] p;
         p = 16'($urandom);
         fifo_q.push_back(p);
         exp_q.push_back(p);
      end
      fifo_count = 10'((fifo_q.size() > 1023) ? 1023 : fifo_q.size());
   endtask

   // one clock: observe at the falling edge, then update FIFO and controller inputs
   task automatic tick();
      @(negedge clk_100);
      cyc++;
      if (wr_valid) begin
         cap_q.push_back(wr_data);
         n_vld++;
         if (vld_first < 0) vld_first = cyc;
         vld_last = cyc;
         if (addr_q.size() > 0 && wr_addr !== addr_q[$]) addr_moved++;
      end
      if (fifo_rd_en) begin
         n_rd++;
         if (rd_first < 0) rd_first = cyc;
      end
      if (wr_req) n_req++;
      if (frame_done) n_done++;
      if (frame_err) begin
         n_err++;
         err_cyc = cyc;
      end
      if (fifo_rd_en && fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
      else fifo_dout = 16'($urandom);
      fifo_count = 10'((fifo_q.size() > 1023) ? 1023 : fifo_q.size());
      if (wr_req && !wr_gnt) begin
         if (gnt_wait >= gnt_delay) begin
            wr_gnt = 1'b1;
            gnt_cyc = cyc;
            if (gnt_first < 0) gnt_first = cyc;
            addr_q.push_back(wr_addr);
            gnt_wait = 0;
            gnt_delay = $urandom_range(0, gnt_max);
         end else begin
            gnt_wait++;
         end
      end else begin
         wr_gnt = 1'b0;
         gnt_wait = 0;
      end
   endtask

   task automatic run_until(input bit on_rd, input int target, input int budget, output bit ok);
      int k;
      k = 0;
      ok = 1'b1;
      while (((on_rd ? n_rd : n_vld) < target) || busy) begin
         if (k == budget) begin
            ok = 1'b0;
            break;
         end
         tick();
         k++;
      end
   endtask

   task automatic pulse_start();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   // pops nwords expected pixels and reports the first beat that differs
   task automatic data_check(input int nwords, output int bad, output logic [15:0] got, output logic [15:0] want);
      bad = -1; got = '0; want = '0;
      for (int i = 0; i < nwords; i++) begin
         logic [15:0] w;
         logic [15:0] c;
         w = (exp_q.size() > 0) ? exp_q.pop_front() : 16'h0000;
         c = (i < cap_q.size()) ? cap_q[i] : 16'hxxxx;
         if (c !== w && bad < 0) begin
            bad = i; got = c; want = w;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; fifo_count = '0; frame_start = 1'b0; wr_gnt = 1'b0; fifo_dout = 16'h5A3C;
      #12;
      n_cmp++; if (fifo_rd_en !== 1'b0) begin n_bad++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
      n_cmp++; if (wr_req !== 1'b0) begin n_bad++; $display("FAIL reset_wr_req: got %b want 0", wr_req); end
      n_cmp++; if (wr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_wr_valid: got %b want 0", wr_valid); end
      n_cmp++; if ({frame_done, frame_err, busy} !== 3'b000) begin n_bad++; $display("FAIL reset_pulses: got %b want 000", {frame_done, frame_err, busy}); end
      n_cmp++; if (wr_addr !== '0) begin n_bad++; $display("FAIL reset_wr_addr: got %h want 0", wr_addr); end
      n_cmp++; if (disp_bank !== 1'b1) begin n_bad++; $display("FAIL reset_disp_bank: got %b want 1", disp_bank); end
      n_cmp++; if (wr_data !== 16'h5A3C) begin n_bad++; $display("FAIL reset_wr_data: got %h want 5a3c", wr_data); end
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_burst_start();
      bit ok; int bad; logic [15:0] g, w;
      clear_stats();
      gnt_delay = 3; gnt_wait = 0;
      push_pixels(BL + 4);
      run_until(1'b0, BL, 200, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL burst_timeout: got %0d beats want %0d", n_vld, BL); end
      n_cmp++; if (addr_q.size() != 1 || addr_q[0] !== m_addr(0)) begin n_bad++; $display("FAIL burst_addr: got %h want %h", (addr_q.size() > 0) ? addr_q[0] : 'x, m_addr(0)); end
      n_cmp++; if (n_req != 4) begin n_bad++; $display("FAIL burst_req_cycles: got %0d want 4", n_req); end
      n_cmp++; if (n_rd != BL) begin n_bad++; $display("FAIL burst_rd_count: got %0d want %0d", n_rd, BL); end
      n_cmp++; if (n_vld != BL) begin n_bad++; $display("FAIL burst_vld_count: got %0d want %0d", n_vld, BL); end
      n_cmp++; if (rd_first != gnt_cyc + 1) begin n_bad++; $display("FAIL burst_first_rd: got %0d want %0d", rd_first, gnt_cyc + 1); end
      n_cmp++; if (vld_first != gnt_cyc + 2) begin n_bad++; $display("FAIL burst_first_vld: got %0d want %0d", vld_first, gnt_cyc + 2); end
      n_cmp++; if (vld_last != gnt_cyc + BL + 1) begin n_bad++; $display("FAIL burst_last_vld: got %0d want %0d", vld_last, gnt_cyc + BL + 1); end
      n_cmp++; if (vld_last - vld_first + 1 != n_vld) begin n_bad++; $display("FAIL burst_contiguous: got span %0d want %0d", vld_last - vld_first + 1, n_vld); end
      n_cmp++; if (addr_moved != 0) begin n_bad++; $display("FAIL burst_addr_stable: got %0d changes want 0", addr_moved); end
      data_check(BL, bad, g, w);
      n_cmp++; if (bad >= 0) begin n_bad++; $display("FAIL burst_data: beat %0d got %h want %h", bad, g, w); end
      m_cnt += BL;
      clear_stats();
      push_pixels(BL - 4);
      run_until(1'b0, BL, 200, ok);
      n_cmp++; if (!ok || addr_q.size() != 1 || addr_q[0] !== m_addr(0)) begin n_bad++; $display("FAIL burst_next_addr: got %h want %h", (addr_q.size() > 0) ? addr_q[0] : 'x, m_addr(0)); end
      data_check(BL, bad, g, w);
      n_cmp++; if (bad >= 0) begin n_bad++; $display("FAIL burst_next_data: beat %0d got %h want %h", bad, g, w); end
      m_cnt += BL;
   endtask

   task automatic test_short_frame();
      bit ok; bit exp_done; int bad; logic [15:0] g, w;
      clear_stats();
      pulse_start();
      repeat (4) tick();
      model_frame_boundary(exp_done);
      n_cmp++; if (n_err != (exp_done ? 0 : 1) || n_done != (exp_done ? 1 : 0)) begin n_bad++; $display("FAIL short_pulses: got done=%0d err=%0d want done=0 err=1", n_done, n_err); end
      n_cmp++; if (disp_bank !== m_disp) begin n_bad++; $display("FAIL short_disp_bank: got %b want %b", disp_bank, m_disp); end
      clear_stats();
      push_pixels(BL);
      run_until(1'b0, BL, 200, ok);
      n_cmp++; if (!ok || addr_q.size() != 1 || addr_q[0] !== m_addr(0)) begin n_bad++; $display("FAIL short_next_addr: got %h want %h", (addr_q.size() > 0) ? addr_q[0] : 'x, m_addr(0)); end
      data_check(BL, bad, g, w);
      n_cmp++; if (bad >= 0) begin n_bad++; $display("FAIL short_data: beat %0d got %h want %h", bad, g, w); end
      m_cnt += BL;
   endtask

   task automatic test_full_frame();
      bit ok; bit exp_done; int bad; int nb; logic [15:0] g, w;
      nb = (FW - m_cnt) / BL;
      clear_stats();
      push_pixels(nb * BL);
      run_until(1'b0, nb * BL, nb * 60 + 50, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL frame_timeout: got %0d beats want %0d", n_vld, nb * BL); end
      for (int i = 0; i < nb; i++) begin
         n_cmp++; if (i >= addr_q.size() || addr_q[i] !== m_addr(i * BL)) begin n_bad++; $display("FAIL frame_addr%0d: got %h want %h", i, (i < addr_q.size()) ? addr_q[i] : 'x, m_addr(i * BL)); end
      end
      data_check(nb * BL, bad, g, w);
      n_cmp++; if (bad >= 0) begin n_bad++; $display("FAIL frame_data: beat %0d got %h want %h", bad, g, w); end
      m_cnt += nb * BL;
      clear_stats();
      pulse_start();
      repeat (4) tick();
      model_frame_boundary(exp_done);
      n_cmp++; if (n_done != 1 || n_err != 0) begin n_bad++; $display("FAIL frame_pulses: got done=%0d err=%0d want done=1 err=0", n_done, n_err); end
      n_cmp++; if (disp_bank !== m_disp) begin n_bad++; $display("FAIL frame_disp_bank: got %b want %b", disp_bank, m_disp); end
      clear_stats();
      push_pixels(BL);
      run_until(1'b0, BL, 200, ok);
      n_cmp++; if (!ok || addr_q.size() != 1 || addr_q[0] !== m_addr(0)) begin n_bad++; $display("FAIL frame_next_addr: got %h want %h", (addr_q.size() > 0) ? addr_q[0] : 'x, m_addr(0)); end
      data_check(BL, bad, g, w);
      m_cnt += BL;
   endtask

   task automatic test_start_during_stream();
      bit ok; bit exp_done; int bad; logic [15:0] g, w;
      clear_stats();
      push_pixels(BL);
      for (int k = 0; k < 60 && rd_first < 0; k++) tick();
      n_cmp++; if (rd_first < 0) begin n_bad++; $display("FAIL mid_no_stream: got no read want reads"); end
      repeat (3) tick();
      pulse_start();
      run_until(1'b0, BL, 200, ok);
      repeat (3) tick();
      m_cnt += BL;
      model_frame_boundary(exp_done);
      n_cmp++; if (n_vld != BL || n_rd != BL) begin n_bad++; $display("FAIL mid_burst_len: got rd=%0d vld=%0d want %0d", n_rd, n_vld, BL); end
      data_check(BL, bad, g, w);
      n_cmp++; if (bad >= 0) begin n_bad++; $display("FAIL mid_data: beat %0d got %h want %h", bad, g, w); end
      n_cmp++; if (n_err != 1 || err_cyc != vld_last + 2) begin n_bad++; $display("FAIL mid_swap_timing: got err=%0d at %0d want 1 at %0d", n_err, err_cyc, vld_last + 2); end
      clear_stats();
      push_pixels(BL);
      run_until(1'b0, BL, 200, ok);
      n_cmp++; if (!ok || addr_q.size() != 1 || addr_q[0] !== m_addr(0)) begin n_bad++; $display("FAIL mid_next_addr: got %h want %h", (addr_q.size() > 0) ? addr_q[0] : 'x, m_addr(0)); end
      data_check(BL, bad, g, w);
      m_cnt += BL;
   endtask

   task automatic test_overrun();
      bit ok; bit exp_done; int bad; int nb; logic [15:0] g, w;
      nb = (FW - m_cnt) / BL;
      clear_stats();
      push_pixels(nb * BL);
      run_until(1'b0, nb * BL, nb * 60 + 50, ok);
      data_check(nb * BL, bad, g, w);
      n_cmp++; if (!ok || bad >= 0) begin n_bad++; $display("FAIL over_fill: got beats=%0d bad=%0d want beats=%0d bad=-1", n_vld, bad, nb * BL); end
      m_cnt += nb * BL;
      clear_stats();
      push_pixels(40);
      run_until(1'b1, 40, 200, ok);
      repeat (3) tick();
      for (int i = 0; i < 40; i++) void'(exp_q.pop_front());
      n_cmp++; if (n_rd != 40) begin n_bad++; $display("FAIL over_reads: got %0d want 40", n_rd); end
      n_cmp++; if (n_vld != 0) begin n_bad++; $display("FAIL over_wr_valid: got %0d want 0", n_vld); end
      n_cmp++; if (n_req != 0) begin n_bad++; $display("FAIL over_wr_req: got %0d want 0", n_req); end
      n_cmp++; if (busy !== 1'b0 || fifo_q.size() != 0) begin n_bad++; $display("FAIL over_idle: got busy=%b left=%0d want 0 0", busy, fifo_q.size()); end
      clear_stats();
      pulse_start();
      repeat (4) tick();
      model_frame_boundary(exp_done);
      n_cmp++; if (n_done != 1 || disp_bank !== m_disp) begin n_bad++; $display("FAIL over_swap: got done=%0d disp=%b want 1 %b", n_done, disp_bank, m_disp); end
   endtask

   task automatic test_back_to_back();
      bit ok; bit exp_done; int bad; int nb; logic [15:0] g, w;
      nb = FW / BL;
      gnt_max = 0; gnt_delay = 0;
      clear_stats();
      push_pixels(FW);
      run_until(1'b0, FW, nb * 60 + 50, ok);
      n_cmp++; if (!ok || vld_last - gnt_first != (nb - 1) * (BL + 3) + BL + 1) begin n_bad++; $display("FAIL b2b_span: got %0d want %0d", vld_last - gnt_first, (nb - 1) * (BL + 3) + BL + 1); end
      for (int i = 0; i < nb; i++) begin
         n_cmp++; if (i >= addr_q.size() || addr_q[i] !== m_addr(i * BL)) begin n_bad++; $display("FAIL b2b_addr%0d: got %h want %h", i, (i < addr_q.size()) ? addr_q[i] : 'x, m_addr(i * BL)); end
      end
      data_check(FW, bad, g, w);
      n_cmp++; if (bad >= 0) begin n_bad++; $display("FAIL b2b_data: beat %0d got %h want %h", bad, g, w); end
      m_cnt += FW;
      gnt_max = 4;
      clear_stats();
      pulse_start();
      repeat (4) tick();
      model_frame_boundary(exp_done);
      n_cmp++; if (n_done != 1 || disp_bank !== m_disp) begin n_bad++; $display("FAIL b2b_swap: got done=%0d disp=%b want 1 %b", n_done, disp_bank, m_disp); end
   endtask

   task automatic test_reset_mid_burst();
      bit ok; int bad; logic [15:0] g, w;
      clear_stats();
      push_pixels(BL);
      for (int k = 0; k < 100 && n_vld < BL / 2; k++) tick();
      n_cmp++; if (n_vld != BL / 2) begin n_bad++; $display("FAIL rst_reach_mid: got %0d beats want %0d", n_vld, BL / 2); end
      rst_n = 1'b0;
      #1;
      n_cmp++; if ({fifo_rd_en, wr_valid, wr_req, busy} !== 4'b0000) begin n_bad++; $display("FAIL rst_mid_ctrl: got rd/vld/req/busy=%b want 0000", {fifo_rd_en, wr_valid, wr_req, busy}); end
      n_cmp++; if (wr_addr !== '0) begin n_bad++; $display("FAIL rst_mid_addr: got %h want 0", wr_addr); end
      n_cmp++; if (disp_bank !== 1'b1) begin n_bad++; $display("FAIL rst_mid_disp: got %b want 1", disp_bank); end
      repeat (2) tick();
      rst_n = 1'b1;
      m_cnt = 0; m_bank = 1'b0; m_disp = 1'b1;
      exp_q = fifo_q;
      repeat (2) tick();
      clear_stats();
      push_pixels(BL);
      run_until(1'b0, BL, 200, ok);
      n_cmp++; if (!ok || addr_q.size() != 1 || addr_q[0] !== m_addr(0)) begin n_bad++; $display("FAIL rst_next_addr: got %h want %h", (addr_q.size() > 0) ? addr_q[0] : 'x, m_addr(0)); end
      data_check(BL, bad, g, w);
      n_cmp++; if (bad >= 0) begin n_bad++; $display("FAIL rst_next_data: beat %0d got %h want %h", bad, g, w); end
   endtask

   initial begin
      test_reset();
      test_burst_start();
      test_short_frame();
      test_full_frame();
      test_start_during_stream();
      test_overrun();
      test_back_to_back();
      test_reset_mid_burst();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion want finish before 500us");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/cam_fifo_sdram_writer.md
# cam_fifo_sdram_writer

Downstream stage of the camera capture path. Drains 16-bit RGB565 pixels from the capture FIFO in fixed-length bursts and writes them into one of two SDRAM frame buffers (ping-pong) through the SDRAM controller's burst-write port. On every frame boundary it swaps buffers only if the finished frame is complete, so the display side always reads a whole frame.

## Interface
Parameters:
- BURST_LEN, 256: words per SDRAM write burst; power of two, ≤ 512.
- FRAME_WORDS, 307200: pixels per frame (640×480); must be a multiple of BURST_LEN.
- ADDR_W, 24: SDRAM word-address width.
- BANK1_BASE, 24'h080000: word base address of buffer 1. Buffer 0 base is 0.

Ports:
- clk_100  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fifo_count  in  10  capture FIFO occupancy (words).
- fifo_dout  in  16  FIFO read data; valid 1 cycle after fifo_rd_en.
- fifo_rd_en  out  1  FIFO read strobe.
- frame_start  in  1  1-cycle pulse on each camera vsync falling edge, already in the clk_100 domain.
- wr_req  out  1  burst-write request to the SDRAM controller.
- wr_gnt  in  1  1-cycle grant from the controller.
- wr_addr  out  ADDR_W  burst base address; stable from wr_req rise to burst end.
- wr_data  out  16  write data (= fifo_dout).
- wr_valid  out  1  wr_data valid; the controller accepts one word on every cycle this is high.
- disp_bank  out  1  buffer holding the last complete frame.
- frame_done  out  1  1-cycle pulse when buffers swap.
- frame_err  out  1  1-cycle pulse when an incomplete frame is dropped.
- busy  out  1  high in any state except IDLE.

## Operation
- Registers:
  - wr_bank: buffer being filled.
  - word_cnt: words written this frame; 19 bits, range 0..FRAME_WORDS.
  - start_pend: latched frame_start.
- States:
  - IDLE
    - If start_pend: go to SWAP.
    - Else if word_cnt == FRAME_WORDS and fifo_count ≠ 0: go to DISCARD.
    - Else if fifo_count ≥ BURST_LEN and word_cnt < FRAME_WORDS: go to REQ.
  - REQ
    - wr_req = 1; wr_addr = (wr_bank ? BANK1_BASE : 0) + word_cnt.
    - On wr_gnt, go to STREAM.
  - STREAM
    - fifo_rd_en = 1 for exactly BURST_LEN consecutive cycles.
    - wr_valid is fifo_rd_en delayed by one cycle.
    - After the last wr_valid cycle: word_cnt += BURST_LEN; go to IDLE.
  - DISCARD
    - fifo_rd_en = 1 while fifo_count ≠ 0 and start_pend = 0; data is dropped and wr_valid stays 0.
    - Return to IDLE when fifo_count = 0 or start_pend = 1.
  - SWAP (1 cycle)
    - If word_cnt == FRAME_WORDS: disp_bank ← wr_bank, wr_bank ← ~wr_bank, pulse frame_done.
    - Otherwise: keep both banks, pulse frame_err.
    - Always: word_cnt ← 0, start_pend ← 0; go to IDLE.
- frame_start sets start_pend in any state; it is serviced only from IDLE, so an in-progress burst always completes.
- frame_start coinciding with SWAP re-sets start_pend; the set has priority over the clear.
- A partial trailing burst (< BURST_LEN words left in the FIFO at frame end) stays in the FIFO and is written at the head of the next frame. Camera framing guarantees FRAME_WORDS per valid frame.

## Timing
- Reset values:
  - state = IDLE.
  - fifo_rd_en, wr_req, wr_valid, frame_done, frame_err, busy = 0.
  - wr_addr, word_cnt, wr_bank, start_pend = 0.
  - wr_data = fifo_dout (not registered).
  - disp_bank = 1.
- wr_req asserts the cycle after IDLE sees the burst condition; it holds until wr_gnt is sampled high and drops on the next cycle.
- First fifo_rd_en: the cycle after wr_gnt. First wr_valid: 2 cycles after wr_gnt. Last wr_valid: BURST_LEN+1 cycles after wr_gnt.
- wr_valid is contiguous; there are no gaps inside a burst.
- Minimum gap between bursts: 2 cycles (IDLE, then REQ).
- Reset mid-burst aborts immediately; the partial burst in SDRAM is abandoned.

## Test plan
1. Burst start:
   - Stimulus: fifo_count = 300, wr_gnt 3 cycles after wr_req.
   - Required: wr_addr = 0; fifo_rd_en for 256 cycles; wr_valid for 256 cycles, lagging by 1; word_cnt = 256; next wr_addr = 256.
2. Full frame then swap:
   - Stimulus: 1200 bursts, then frame_start.
   - Required: frame_done pulses once; disp_bank = 0; wr_bank = 1; next wr_addr = 24'h080000.
3. Short frame:
   - Stimulus: frame_start after 10 bursts.
   - Required: frame_err pulses; disp_bank stays 1; next wr_addr = 0.
4. frame_start during STREAM:
   - Required: the burst finishes all 256 words; SWAP occurs 1 cycle after return to IDLE.
5. Overrun:
   - Stimulus: word_cnt = FRAME_WORDS, fifo_count = 40.
   - Required: 40 FIFO reads; wr_valid = 0; wr_req = 0.
6. Reset mid-burst:
   - Stimulus: assert rst_n = 0 at word 100 of a burst.
   - Required: all outputs at reset values in the same cycle; disp_bank = 1.
